// File: rtl/midi_rx_parser_if.sv
// Signal bundle between the MIDI receive parser and its consumer.
// The parser drives the decoded strobes and samples the raw serial line.
`timescale 1ns/1ps
interface midi_rx_parser_if;
  logic       rx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic [1:0] msg_len;
  logic       rt_valid;
  logic [7:0] rt_byte;
  logic       sysex_valid;
  logic [7:0] sysex_data;

  modport master (
    input  rx,
    output byte_valid, byte_data, frame_err,
    output msg_valid, msg_status, msg_d1, msg_d2, msg_len,
    output rt_valid, rt_byte, sysex_valid, sysex_data
  );

  modport slave (
    output rx,
    input  byte_valid, byte_data, frame_err,
    input  msg_valid, msg_status, msg_d1, msg_d2, msg_len,
    input  rt_valid, rt_byte, sysex_valid, sysex_data
  );
endinterface

// File: rtl/midi_rx_parser.sv
// MIDI 8N1 receiver plus message parser with running status and real-time split.
// Define MIDI_SYSEX_EN to forward SysEx bytes on sysex_valid/sysex_data.
`timescale 1ns/1ps
module midi_rx_parser #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 31250
) (
  input  logic          clk_sys,
  input  logic          reset,
  midi_rx_parser_if.master midi
);

  localparam int          DIV     = (CLK_HZ + BAUD / 2) / BAUD;
  localparam logic [15:0] DIV_M1  = 16'(DIV - 1);
  localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);

`ifdef MIDI_SYSEX_EN
  localparam bit SYSEX_EN = 1'b1;
`else
  localparam bit SYSEX_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK
  } uart_state_t;

  uart_state_t uart_state_reg, uart_state_next;
  logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic [15:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0]  bit_idx_reg, bit_idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic        byte_valid_reg, byte_valid_next;
  logic [7:0]  byte_data_reg, byte_data_next;
  logic        frame_err_reg, frame_err_next;

  logic [7:0]  run_status_reg, run_status_next;
  logic [1:0]  need_reg, need_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [6:0]  d1_reg, d1_next;
  logic        sysex_reg, sysex_next;
  logic        sysex_emit;
  logic        msg_valid_reg, msg_valid_next;
  logic [7:0]  msg_status_reg, msg_status_next;
  logic [6:0]  msg_d1_reg, msg_d1_next;
  logic [6:0]  msg_d2_reg, msg_d2_next;
  logic [1:0]  msg_len_reg, msg_len_next;
  logic        rt_valid_reg, rt_valid_next;
  logic [7:0]  rt_byte_reg, rt_byte_next;
  logic        sysex_valid_reg, sysex_valid_next;
  logic [7:0]  sysex_data_reg, sysex_data_next;

  // The edge detector keeps tracking through reset so a line already low
  // at release is not mistaken for a start bit.
  always_ff @(posedge clk_sys) begin
    rx_meta_reg <= midi.rx;
    rx_sync_reg <= rx_meta_reg;
    rx_prev_reg <= rx_sync_reg;
  end

  always_comb begin
    uart_state_next = uart_state_reg;
    bit_cnt_next    = bit_cnt_reg + 16'd1;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid_next = 1'b0;
    byte_data_next  = byte_data_reg;
    frame_err_next  = 1'b0;
    case (uart_state_reg)
      ST_IDLE: begin
        bit_cnt_next = 16'd0;
        if (rx_prev_reg && !rx_sync_reg) uart_state_next = ST_START;
      end
      ST_START: if (bit_cnt_reg == HALF_M1) begin
        bit_cnt_next    = 16'd0;
        bit_idx_next    = 3'd0;
        uart_state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (bit_cnt_reg == DIV_M1) begin
        bit_cnt_next = 16'd0;
        shift_next   = {rx_sync_reg, shift_reg[7:1]};
        bit_idx_next = bit_idx_reg + 3'd1;
        if (bit_idx_reg == 3'd7) uart_state_next = ST_STOP;
      end
      ST_STOP: if (bit_cnt_reg == DIV_M1) begin
        bit_cnt_next = 16'd0;
        if (rx_sync_reg) begin
          byte_valid_next = 1'b1;
          byte_data_next  = shift_reg;
          uart_state_next = ST_IDLE;
        end else begin
          frame_err_next  = 1'b1;
          uart_state_next = ST_BREAK;
        end
      end
      ST_BREAK: begin
        bit_cnt_next = 16'd0;
        if (rx_sync_reg) uart_state_next = ST_IDLE;
      end
      default: uart_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    run_status_next = run_status_reg;
    need_next       = need_reg;
    cnt_next        = cnt_reg;
    d1_next         = d1_reg;
    sysex_next      = sysex_reg;
    sysex_emit      = 1'b0;
    msg_valid_next  = 1'b0;
    msg_status_next = msg_status_reg;
    msg_d1_next     = msg_d1_reg;
    msg_d2_next     = msg_d2_reg;
    msg_len_next    = msg_len_reg;
    rt_valid_next   = 1'b0;
    rt_byte_next    = rt_byte_reg;
    if (byte_valid_reg) begin
      if (byte_data_reg >= 8'hF8) begin
        rt_valid_next = 1'b1;
        rt_byte_next  = byte_data_reg;
      end else if (sysex_reg && (!byte_data_reg[7] || byte_data_reg == 8'hF7)) begin
        sysex_emit = 1'b1;
        if (byte_data_reg[7]) sysex_next = 1'b0;
      end else if (byte_data_reg[7]) begin
        // Any status other than 0xF7 also terminates SysEx and is then handled here.
        sysex_next = 1'b0;
        if (byte_data_reg < 8'hF0) begin
          run_status_next = byte_data_reg;
          need_next       = (byte_data_reg[7:5] == 3'b110) ? 2'd1 : 2'd2;
          cnt_next        = 2'd0;
        end else begin
          case (byte_data_reg)
            8'hF0: begin
              run_status_next = 8'h00;
              need_next       = 2'd0;
              cnt_next        = 2'd0;
              sysex_next      = 1'b1;
              sysex_emit      = 1'b1;
            end
            8'hF1, 8'hF3, 8'hF2: begin
              run_status_next = byte_data_reg;
              need_next       = (byte_data_reg == 8'hF2) ? 2'd2 : 2'd1;
              cnt_next        = 2'd0;
            end
            8'hF6: begin
              msg_valid_next  = 1'b1;
              msg_status_next = 8'hF6;
              msg_d1_next     = 7'd0;
              msg_d2_next     = 7'd0;
              msg_len_next    = 2'd0;
              run_status_next = 8'h00;
              need_next       = 2'd0;
              cnt_next        = 2'd0;
            end
            8'hF4, 8'hF5: begin
              run_status_next = 8'h00;
              need_next       = 2'd0;
              cnt_next        = 2'd0;
            end
            default: ;
          endcase
        end
      end else if (need_reg != 2'd0) begin
        if (cnt_reg + 2'd1 == need_reg) begin
          msg_valid_next  = 1'b1;
          msg_status_next = run_status_reg;
          msg_d1_next     = (need_reg == 2'd1) ? byte_data_reg[6:0] : d1_reg;
          msg_d2_next     = (need_reg == 2'd2) ? byte_data_reg[6:0] : 7'd0;
          msg_len_next    = need_reg;
          cnt_next        = 2'd0;
          if (run_status_reg[7:4] == 4'hF) begin
            run_status_next = 8'h00;
            need_next       = 2'd0;
          end
        end else begin
          d1_next  = byte_data_reg[6:0];
          cnt_next = cnt_reg + 2'd1;
        end
      end
    end
    sysex_valid_next = SYSEX_EN && sysex_emit;
    sysex_data_next  = (SYSEX_EN && sysex_emit) ? byte_data_reg : sysex_data_reg;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      uart_state_reg  <= ST_IDLE;
      bit_cnt_reg     <= 16'd0;
      bit_idx_reg     <= 3'd0;
      shift_reg       <= 8'h00;
      byte_valid_reg  <= 1'b0;
      byte_data_reg   <= 8'h00;
      frame_err_reg   <= 1'b0;
      run_status_reg  <= 8'h00;
      need_reg        <= 2'd0;
      cnt_reg         <= 2'd0;
      d1_reg          <= 7'd0;
      sysex_reg       <= 1'b0;
      msg_valid_reg   <= 1'b0;
      msg_status_reg  <= 8'h00;
      msg_d1_reg      <= 7'd0;
      msg_d2_reg      <= 7'd0;
      msg_len_reg     <= 2'd0;
      rt_valid_reg    <= 1'b0;
      rt_byte_reg     <= 8'h00;
      sysex_valid_reg <= 1'b0;
      sysex_data_reg  <= 8'h00;
    end else begin
      uart_state_reg  <= uart_state_next;
      bit_cnt_reg     <= bit_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      byte_valid_reg  <= byte_valid_next;
      byte_data_reg   <= byte_data_next;
      frame_err_reg   <= frame_err_next;
      run_status_reg  <= run_status_next;
      need_reg        <= need_next;
      cnt_reg         <= cnt_next;
      d1_reg          <= d1_next;
      sysex_reg       <= sysex_next;
      msg_valid_reg   <= msg_valid_next;
      msg_status_reg  <= msg_status_next;
      msg_d1_reg      <= msg_d1_next;
      msg_d2_reg      <= msg_d2_next;
      msg_len_reg     <= msg_len_next;
      rt_valid_reg    <= rt_valid_next;
      rt_byte_reg     <= rt_byte_next;
      sysex_valid_reg <= sysex_valid_next;
      sysex_data_reg  <= sysex_data_next;
    end
  end

  assign midi.byte_valid  = byte_valid_reg;
  assign midi.byte_data   = byte_data_reg;
  assign midi.frame_err   = frame_err_reg;
  assign midi.msg_valid   = msg_valid_reg;
  assign midi.msg_status  = msg_status_reg;
  assign midi.msg_d1      = msg_d1_reg;
  assign midi.msg_d2      = msg_d2_reg;
  assign midi.msg_len     = msg_len_reg;
  assign midi.rt_valid    = rt_valid_reg;
  assign midi.rt_byte     = rt_byte_reg;
  assign midi.sysex_valid = sysex_valid_reg;
  assign midi.sysex_data  = sysex_data_reg;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser: directed scenarios followed by random
// MIDI byte streams checked against a message-level reference model.
`timescale 1ns/1ps
module tb_midi_rx_parser;

  localparam int DIV = 32;

  typedef struct packed {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    logic [1:0] len;
  } msg_t;

  localparam logic [7:0] DIR_SEQ [21] = '{
    8'h90, 8'h3C, 8'h64,
    8'h90, 8'h3C, 8'h64, 8'h40, 8'h00,
    8'hB0, 8'h07, 8'hF8, 8'h7F,
    8'hC5, 8'h0A, 8'hF6, 8'h12,
    8'hF0, 8'h41, 8'h10, 8'hF7, 8'h20
  };

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;

  midi_rx_parser_if bus ();

  midi_rx_parser #(.CLK_HZ(1_000_000), .BAUD(31250)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .midi    (bus)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard queues, filled at issue time and drained by the monitor
  logic [7:0] exp_byte_q[$];
  logic [7:0] exp_rt_q[$];
  logic [7:0] exp_sysex_q[$];
  msg_t       exp_msg_q[$];
  int         start_q[$];
  int         exp_ferr = 0;
  logic       chk_reset_req = 1'b0;
  logic       final_req = 1'b0;

  // Reference model state: current status and data bytes collected so far
  logic [7:0] m_status = 8'h00;
  logic [6:0] m_data[$];
  bit         m_sysex = 1'b0;

  function automatic int len_for(input logic [7:0] st);
    if (st >= 8'hC0 && st <= 8'hDF) return 1;
    if (st == 8'hF1 || st == 8'hF3) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_status = 8'h00;
    m_data.delete();
    m_sysex = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    msg_t m;
    exp_byte_q.push_back(b);
    if (b >= 8'hF8) begin
      exp_rt_q.push_back(b);
      return;
    end
    if (m_sysex) begin
      if (b < 8'h80 || b == 8'hF7) begin
`ifdef MIDI_SYSEX_EN
        exp_sysex_q.push_back(b);
`endif
        if (b == 8'hF7) m_sysex = 1'b0;
        return;
      end
      m_sysex = 1'b0;
    end
    if (b < 8'h80) begin
      if (m_status != 8'h00) begin
        m_data.push_back(b[6:0]);
        if (m_data.size() == len_for(m_status)) begin
          m.st  = m_status;
          m.len = 2'(m_data.size());
          m.d1  = m_data[0];
          m.d2  = (m_data.size() == 2) ? m_data[1] : 7'd0;
          exp_msg_q.push_back(m);
          m_data.delete();
          if (m_status >= 8'hF0) m_status = 8'h00;
        end
      end
    end else if (b != 8'hF7) begin
      m_data.delete();
      if (b < 8'hF0 || b == 8'hF1 || b == 8'hF2 || b == 8'hF3) begin
        m_status = b;
      end else begin
        m_status = 8'h00;
        if (b == 8'hF0) begin
          m_sysex = 1'b1;
`ifdef MIDI_SYSEX_EN
          exp_sysex_q.push_back(b);
`endif
        end
        if (b == 8'hF6) begin
          m.st = 8'hF6; m.d1 = 7'd0; m.d2 = 7'd0; m.len = 2'd0;
          exp_msg_q.push_back(m);
        end
      end
    end
  endtask

  task automatic bit_time();
    repeat (DIV) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) model_byte(b);
    else exp_ferr++;
    @(posedge clk_sys);
    #1;
    bus.rx = 1'b0;
    start_q.push_back(cyc);
    bit_time();
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      bit_time();
    end
    bus.rx = stop_ok;
    bit_time();
    if (!stop_ok) begin
      bus.rx = 1'b1;
      bit_time();
    end
    bus.rx = 1'b1;
    repeat ($urandom_range(2, 20)) @(posedge clk_sys);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) return 8'($urandom_range(0, 127));
    if (r < 65) return {4'($urandom_range(8, 14)), 4'($urandom_range(0, 15))};
    if (r < 72) return 8'($urandom_range(248, 255));
    if (r < 80) return 8'($urandom_range(241, 243));
    if (r < 84) return 8'hF6;
    if (r < 87) return 8'($urandom_range(244, 245));
    if (r < 93) return 8'hF0;
    return 8'hF7;
  endfunction

  // Monitor: the only process that counts comparisons
  int checks = 0;
  int failures = 0;
  int ferr_seen = 0;

  always @(negedge clk_sys) begin
    msg_t got, exp;
    int   lat;
    logic [7:0] eb;
    if (bus.byte_valid) begin
      checks++;
      if (exp_byte_q.size() == 0) begin
        failures++;
        $display("FAIL byte_unexpected got=%02h required=none", bus.byte_data);
      end else begin
        eb = exp_byte_q.pop_front();
        if (bus.byte_data !== eb) begin
          failures++;
          $display("FAIL byte_data got=%02h required=%02h", bus.byte_data, eb);
        end else $display("byte %02h", bus.byte_data);
      end
      if (start_q.size() != 0) begin
        lat = cyc - start_q.pop_front();
        checks++;
        if (lat < 305 || lat > 307) begin
          failures++;
          $display("FAIL byte_latency got=%0d required=305..307", lat);
        end
      end
    end
    if (bus.frame_err) begin
      ferr_seen++;
      if (start_q.size() != 0) void'(start_q.pop_front());
      $display("frame_err");
    end
    if (bus.msg_valid) begin
      got = '{st: bus.msg_status, d1: bus.msg_d1, d2: bus.msg_d2, len: bus.msg_len};
      checks++;
      if (exp_msg_q.size() == 0) begin
        failures++;
        $display("FAIL msg_unexpected got=%02h/%02h/%02h/%0d required=none",
                 got.st, got.d1, got.d2, got.len);
      end else begin
        exp = exp_msg_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL msg got=%02h/%02h/%02h/%0d required=%02h/%02h/%02h/%0d",
                   got.st, got.d1, got.d2, got.len, exp.st, exp.d1, exp.d2, exp.len);
        end else $display("msg status=%02h d1=%02h d2=%02h len=%0d",
                          got.st, got.d1, got.d2, got.len);
      end
    end
    if (bus.rt_valid) begin
      checks++;
      if (exp_rt_q.size() == 0) begin
        failures++;
        $display("FAIL rt_unexpected got=%02h required=none", bus.rt_byte);
      end else begin
        eb = exp_rt_q.pop_front();
        if (bus.rt_byte !== eb) begin
          failures++;
          $display("FAIL rt_byte got=%02h required=%02h", bus.rt_byte, eb);
        end else $display("rt %02h", bus.rt_byte);
      end
    end
    if (bus.sysex_valid) begin
      checks++;
      if (exp_sysex_q.size() == 0) begin
        failures++;
        $display("FAIL sysex_unexpected got=%02h required=none", bus.sysex_data);
      end else begin
        eb = exp_sysex_q.pop_front();
        if (bus.sysex_data !== eb) begin
          failures++;
          $display("FAIL sysex_data got=%02h required=%02h", bus.sysex_data, eb);
        end else $display("sysex %02h", bus.sysex_data);
      end
    end
    if (chk_reset_req) begin
      checks++;
      if ({bus.byte_valid, bus.byte_data, bus.frame_err, bus.msg_valid, bus.msg_status,
           bus.msg_d1, bus.msg_d2, bus.msg_len, bus.rt_valid, bus.rt_byte,
           bus.sysex_valid, bus.sysex_data} !== 53'd0) begin
        failures++;
        $display("FAIL reset_outputs got=nonzero required=all zero (msg=%02h byte=%02h rt=%02h)",
                 bus.msg_status, bus.byte_data, bus.rt_byte);
      end
    end
    if (final_req) begin
      checks++;
      if (ferr_seen != exp_ferr) begin
        failures++;
        $display("FAIL frame_err_count got=%0d required=%0d", ferr_seen, exp_ferr);
      end
      checks++;
      if (exp_msg_q.size() + exp_byte_q.size() + exp_rt_q.size() + exp_sysex_q.size() != 0) begin
        failures++;
        $display("FAIL pending_expected got=%0d/%0d/%0d/%0d required=0/0/0/0",
                 exp_msg_q.size(), exp_byte_q.size(), exp_rt_q.size(), exp_sysex_q.size());
      end
`ifndef MIDI_SYSEX_EN
      checks++;
      if (bus.sysex_data !== 8'h00) begin
        failures++;
        $display("FAIL sysex_tied got=%02h required=00", bus.sysex_data);
      end
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    repeat (90000) @(posedge clk_sys);
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (5) @(posedge clk_sys);
    #1 chk_reset_req = 1'b1;
    @(negedge clk_sys);
    #1 chk_reset_req = 1'b0;
    reset = 1'b0;
    repeat (10) @(posedge clk_sys);

    foreach (DIR_SEQ[i]) send_byte(DIR_SEQ[i], 1'b1);

    send_byte(8'h55, 1'b0);
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);

    // Reset during a partial message and during a start bit
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(posedge clk_sys);
    #1 bus.rx = 1'b0;
    repeat (100) @(posedge clk_sys);
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk_sys);
    #1 chk_reset_req = 1'b1;
    @(negedge clk_sys);
    #1 chk_reset_req = 1'b0;
    reset = 1'b0;
    repeat (400) @(posedge clk_sys);
    #1 bus.rx = 1'b1;
    repeat (20) @(posedge clk_sys);
    send_byte(8'h40, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);

    for (int n = 0; n < 60; n++) send_byte(rand_byte(), ($urandom_range(0, 19) != 0));

    repeat (50) @(posedge clk_sys);
    #1 final_req = 1'b1;
  end

endmodule
